// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared encodings and default latencies for the CPU pipeline control
package cpu_ctrl_pkg;

    // MDU occupancy state
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    // Busy cycles after issue for mult/multu and div/divu
    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;
    localparam int CNT_W_DEF    = 4;

endpackage

// File: rtl/mdu_busy_cnt.sv
// rtl/mdu_busy_cnt.sv - MDU occupancy countdown with retire pulse and sticky protocol error
module mdu_busy_cnt
    import cpu_ctrl_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic e_start,
    input  logic e_is_div,
    input  logic hold,
    output logic busy,
    output logic mdu_done,
    output logic err
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MULT = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_LAT);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mdu_done_q, mdu_done_d;
    logic             err_q, err_d;
    logic             accept;
    logic             start_in_busy;

    // Start qualification; reset masks the start so busy reads 0 while reset is held
    always_comb begin
        accept        = e_start & ~hold & ~reset & (state_q == ST_IDLE);
        start_in_busy = e_start & ~hold & (state_q == ST_BUSY);
        busy          = ~reset & (accept | (state_q == ST_BUSY));
    end

    // Next-state: load latency on accept, count down through hold, retire at cnt==1
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mdu_done_d = 1'b0;
        err_d      = err_q | start_in_busy;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cnt_d   = e_is_div ? CNT_DIV : CNT_MULT;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_q == CNT_ONE) begin
                    state_d    = ST_IDLE;
                    cnt_d      = '0;
                    mdu_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State register with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            mdu_done_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mdu_done_q <= mdu_done_d;
            err_q      <= err_d;
        end
    end

    assign mdu_done = mdu_done_q;
    assign err      = err_q;

    // The countdown retires at 1, so BUSY with a zero count means the counter wrapped
    a_no_busy_zero: assert property (@(posedge clk) disable iff (reset)
        (state_q == ST_BUSY) |-> (cnt_q != '0));

endmodule

// File: rtl/mdu_stall_ctrl.sv
// rtl/mdu_stall_ctrl.sv - pipeline register enable/flush sequencer around the multi-cycle MDU
module mdu_stall_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic E_start,
    input  logic E_is_div,
    input  logic D_use_mdu,
    input  logic D_stall_other,
    input  logic hold,
    output logic busy,
    output logic mdu_done,
    output logic F_en,
    output logic FD_en,
    output logic DE_en,
    output logic DE_refresh,
    output logic EM_en,
    output logic MW_en,
    output logic err
);

    logic dstall;

    mdu_busy_cnt #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT),
        .CNT_W    (CNT_W)
    ) u_busy_cnt (
        .clk      (clk),
        .reset    (reset),
        .e_start  (E_start),
        .e_is_div (E_is_div),
        .hold     (hold),
        .busy     (busy),
        .mdu_done (mdu_done),
        .err      (err)
    );

    // D stalls on an MDU instruction meeting a busy MDU or on any hazard-unit request;
    // hold freezes every register and suppresses the bubble
    always_comb begin
        dstall     = (D_use_mdu & busy) | D_stall_other;
        F_en       = 1'b0;
        FD_en      = 1'b0;
        DE_en      = 1'b0;
        DE_refresh = 1'b0;
        EM_en      = 1'b0;
        MW_en      = 1'b0;
        if (!hold) begin
            F_en       = ~dstall;
            FD_en      = ~dstall;
            DE_en      = 1'b1;
            DE_refresh = dstall;
            EM_en      = 1'b1;
            MW_en      = 1'b1;
        end
    end

endmodule

// File: tb/tb_mdu_stall_ctrl.sv
// tb/tb_mdu_stall_ctrl.sv - scoreboard bench for mdu_stall_ctrl
module tb_mdu_stall_ctrl;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic E_start = 1'b0, E_is_div = 1'b0, D_use_mdu = 1'b0, D_stall_other = 1'b0, hold = 1'b0;
    logic busy, mdu_done, F_en, FD_en, DE_en, DE_refresh, EM_en, MW_en, err;

    always #5 clk = ~clk;

    mdu_stall_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .E_start(E_start), .E_is_div(E_is_div),
        .D_use_mdu(D_use_mdu), .D_stall_other(D_stall_other), .hold(hold),
        .busy(busy), .mdu_done(mdu_done), .F_en(F_en), .FD_en(FD_en), .DE_en(DE_en),
        .DE_refresh(DE_refresh), .EM_en(EM_en), .MW_en(MW_en), .err(err)
    );

    typedef struct {
        int         cyc;
        logic [8:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   stim_done = 0;

    // Reference model: an accepted op occupies absolute cycles t..t+LAT, retires at t+LAT+1
    int cyc       = 0;
    int busy_last = -1;
    int done_at   = -1;
    bit m_err     = 0;

    task automatic step(input logic st, input logic dv, input logic use_m,
                        input logic oth, input logic hd, input logic rs);
        bit   idle, acc, b, ds;
        logic [8:0] e;
        exp_t item;
        @(posedge clk);
        #1;
        E_start = st; E_is_div = dv; D_use_mdu = use_m;
        D_stall_other = oth; hold = hd; reset = rs;
        idle = (cyc > busy_last);
        acc  = st && !hd && idle && !rs;
        b    = !rs && (acc || !idle);
        ds   = (use_m && b) || oth;
        if (hd) e = {b, (done_at == cyc), 6'b000000, m_err};
        else    e = {b, (done_at == cyc), !ds, !ds, 1'b1, ds, 1'b1, 1'b1, m_err};
        item.cyc = cyc;
        item.exp = e;
        exp_q.push_back(item);
        if (rs) begin
            busy_last = cyc;
            done_at   = -1;
            m_err     = 0;
        end else begin
            if (acc) begin
                busy_last = cyc + (dv ? DIV_LAT : MULT_LAT);
                done_at   = busy_last + 1;
            end
            if (st && !hd && !idle) m_err = 1;
        end
        cyc++;
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: pops one expectation per cycle, away from the active edge
    initial begin
        exp_t it;
        logic [8:0] act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                it  = exp_q.pop_front();
                act = {busy, mdu_done, F_en, FD_en, DE_en, DE_refresh, EM_en, MW_en, err};
                checks++;
                if (act !== it.exp) begin
                    errors++;
                    $display("FAIL outputs cyc=%0d {busy,done,F,FD,DE,DEref,EM,MW,err} got=%b want=%b",
                             it.cyc, act, it.exp);
                end
            end
        end
    end

    initial begin
        // reset, then mult at t0
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0);
        idle_n(8);
        // div at t0, D_use_mdu held from t1
        step(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 13; i++) step(0, 0, 1, 0, 0, 0);
        idle_n(2);
        // start while busy at cycle 3 of a mult
        step(1, 0, 0, 0, 0, 0);
        idle_n(2);
        step(1, 1, 0, 0, 0, 0);
        idle_n(6);
        step(0, 0, 0, 0, 0, 1);
        // hold during cycles 2..4 of a mult
        step(1, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 1, 0);
        idle_n(5);
        // start under hold in IDLE, then re-presented without hold
        step(1, 1, 1, 0, 1, 0);
        step(1, 1, 1, 0, 0, 0);
        idle_n(12);
        // back-to-back: start in the same cycle as mdu_done
        step(1, 0, 0, 0, 0, 0);
        idle_n(5);
        step(1, 0, 0, 0, 0, 0);
        idle_n(7);
        // reset at cycle 4 of a div, with err set beforehand
        step(1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        idle_n(2);
        step(0, 0, 0, 0, 0, 1);
        idle_n(12);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 3) == 0), $urandom_range(0, 1),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 6) == 0),
                 ($urandom_range(0, 6) == 0), ($urandom_range(0, 99) < 2));
        end
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
